byte_scan_ctrl: RTL and testbench
=================================

# byte_scan_ctrl

Controller that owns a small bank of byte registers entered from the board switches and schedules which entry is shown on the two-digit hex display. It sits between the key edge detectors (one-cycle `push` pulses) and the pair of hex-to-segment decoders: key pulses load, clear or start/stop an automatic scroll, and `disp` drives the decoders (`disp[3:0]` to the low digit, `disp[7:4]` to the high digit).

## Interface
Parameters:
- `DEPTH`, 4: number of byte entries; power of two, at least 2.
- `TICK_DIV`, 50_000_000: `clk` cycles per scroll step in RUN; at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `load_p`  in  1  one-cycle pulse: store `sw` into the next free entry.
- `clr_p`  in  1  one-cycle pulse: clear the whole bank.
- `run_p`  in  1  one-cycle pulse: toggle between EDIT and RUN.
- `sw`  in  8  switch byte sampled on `load_p`.
- `disp`  out  8  byte to display.
- `disp_idx`  out  log2(DEPTH)  index of the displayed entry.
- `count`  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `full`  out  1  high when `count == DEPTH`.
- `running`  out  1  high in RUN.
- `busy`  out  1  high in CLEAR.

## Operation
- State: `mem[0..DEPTH-1]` (8 bits each), `wr_ptr`, `count`, `disp_idx`, tick counter `tick` (0..TICK_DIV-1), clear index `cidx`, FSM state in {EDIT, RUN, CLEAR}.
- Reset (`rst_n` low at an edge): state EDIT, all `mem` = 0, `wr_ptr` = 0, `count` = 0, `disp_idx` = 0, `tick` = 0, `cidx` = 0. Reset overrides all pulses and aborts any state, including a CLEAR in progress.
- `disp` = `mem[disp_idx]` when `count > 0`; otherwise 8'h00. `full`, `running`, `busy` are decoded from registered state.
- Pulse priority when several pulses arrive in one cycle: `clr_p` > `load_p` > `run_p`. Only the highest-priority applicable pulse acts.
- EDIT:
  - `load_p` with `count < DEPTH`: `mem[wr_ptr] <= sw`, `wr_ptr++`, `count++`, `disp_idx <= wr_ptr`, so the newest entry is shown.
  - `load_p` with `full`: ignored; nothing changes.
  - `run_p` with `count > 0`: go to RUN, `disp_idx <= 0`, `tick <= 0`. With `count == 0`: ignored.
- RUN:
  - `tick` increments every cycle. At `TICK_DIV-1` it wraps to 0, and `disp_idx` advances to `disp_idx+1`, or to 0 when `disp_idx == count-1`.
  - `run_p`: go to EDIT; `disp_idx` keeps its value; `tick <= 0`.
  - `load_p`: ignored. A simultaneous `load_p` and `run_p` in RUN therefore toggles back to EDIT without loading.
- CLEAR (entered on `clr_p` from EDIT or RUN):
  - Each cycle `mem[cidx] <= 0` and `cidx++`.
  - After DEPTH cycles (`cidx == DEPTH-1` written), go to EDIT with `count` = 0, `wr_ptr` = 0, `disp_idx` = 0, `cidx` = 0.
  - `count` is zeroed on entry, so `disp` reads 0 throughout CLEAR.
  - All pulses are ignored while `busy`.
- `wr_ptr` never wraps past a full bank; the only way to free entries is CLEAR or reset.

## Timing
- Load: `load_p` high in cycle n → `mem`, `count`, `disp_idx`, `disp` = `sw` valid from cycle n+1.
- Run start: `run_p` in cycle n → `running` = 1 and `disp_idx` = 0 from n+1. The first advance is visible at n+1+TICK_DIV; after that, one advance every TICK_DIV cycles.
- Clear: `clr_p` in cycle n → `busy` = 1 from n+1 through n+DEPTH; EDIT with `busy` = 0 at n+DEPTH+1.
- `busy`, `running`, `full` change only on clock edges; there is no combinational path from pulse inputs to outputs.

## Test plan
- Reset, then load 8'hA5, 8'h3C → `count` = 2, `disp_idx` = 1, `disp` = 8'h3C one cycle after the second pulse.
- DEPTH=4: load 5 bytes 8'h01..8'h05 → `full` = 1 after the 4th load; the 5th is ignored (`mem[3]` = 8'h04, `count` = 4).
- TICK_DIV=4, 3 entries 8'h11/8'h22/8'h33, `run_p` → `disp` sequence 11,22,33,11 with a change every 4 cycles. Then `run_p` → `running` = 0 and `disp_idx` frozen.
- In RUN, pulse `clr_p`, `load_p` and `run_p` in the same cycle → CLEAR entered, `busy` = 1 for exactly 4 cycles, then EDIT with `count` = 0 and `disp` = 8'h00; pulses during `busy` have no effect.
- `run_p` with an empty bank → stays in EDIT. Assert `rst_n` = 0 for one cycle mid-CLEAR → EDIT, all entries 0, `busy` = 0 on the next cycle.

Source files
------------

// File: rtl/byte_scan_ctrl.sv
// byte_scan_ctrl
// Owns a small bank of byte entries loaded from the board switches and
// chooses which entry drives the two-digit hex display. Key pulses load an
// entry, clear the bank, or start/stop an automatic scroll through the
// valid entries.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset
//   load_p    one-cycle pulse: store sw into the next free entry
//   clr_p     one-cycle pulse: clear the whole bank
//   run_p     one-cycle pulse: toggle between EDIT and RUN
//   sw        switch byte sampled on load_p
//   disp      byte to display (mem[disp_idx], or 0 when the bank is empty)
//   disp_idx  index of the displayed entry
//   count     number of valid entries, 0..DEPTH
//   full      count == DEPTH
//   running   high while scrolling (RUN)
//   busy      high while the bank is being cleared (CLEAR)
module byte_scan_ctrl #(
   parameter int DEPTH    = 4,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_p,
   input  logic                       clr_p,
   input  logic                       run_p,
   input  logic [7:0]                 sw,
   output logic [7:0]                 disp,
   output logic [$clog2(DEPTH)-1:0]   disp_idx,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       running,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {EDIT, RUN, CLEAR} state_t;

   state_t          state, state_next;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   cidx;
   logic [TW-1:0]   tick;

   logic do_load, do_start, do_stop, do_clr, run_step, tick_wrap, clr_done;

   // Next-state and action decode. Pulse priority is clr_p > load_p > run_p;
   // a pulse that cannot act (load into a full bank, run on an empty bank)
   // does not block a lower-priority one.
   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      do_start   = 1'b0;
      do_stop    = 1'b0;
      do_clr     = 1'b0;
      run_step   = 1'b0;
      tick_wrap  = 1'b0;
      clr_done   = 1'b0;
      case (state)
         EDIT: begin
            if (clr_p) begin
               do_clr     = 1'b1;
               state_next = CLEAR;
            end else if (load_p && !full) begin
               do_load = 1'b1;
            end else if (run_p && count != '0) begin
               do_start   = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (clr_p) begin
               do_clr     = 1'b1;
               state_next = CLEAR;
            end else if (run_p) begin
               do_stop    = 1'b1;
               state_next = EDIT;
            end else begin
               run_step  = 1'b1;
               tick_wrap = (tick == TW'(TICK_DIV - 1));
            end
         end
         CLEAR: begin
            clr_done = (cidx == AW'(DEPTH - 1));
            if (clr_done) state_next = EDIT;
         end
         default: state_next = EDIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EDIT;
         wr_ptr   <= '0;
         count    <= '0;
         disp_idx <= '0;
         tick     <= '0;
         cidx     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         state <= state_next;

         if (do_clr) begin
            // count drops at entry so the display blanks for the whole clear
            count <= '0;
            tick  <= '0;
            cidx  <= '0;
         end

         if (do_load) begin
            mem[wr_ptr] <= sw;
            wr_ptr      <= wr_ptr + AW'(1);
            count       <= count + CW'(1);
            disp_idx    <= wr_ptr;
         end

         if (do_start) begin
            disp_idx <= '0;
            tick     <= '0;
         end

         if (do_stop) tick <= '0;

         if (run_step) begin
            if (tick_wrap) begin
               tick <= '0;
               // wrap the scroll at the last valid entry, not at DEPTH-1
               if ({1'b0, disp_idx} == count - CW'(1)) disp_idx <= '0;
               else                                    disp_idx <= disp_idx + AW'(1);
            end else begin
               tick <= tick + TW'(1);
            end
         end

         if (state == CLEAR) begin
            mem[cidx] <= 8'h00;
            cidx      <= cidx + AW'(1);
            if (clr_done) begin
               cidx     <= '0;
               count    <= '0;
               wr_ptr   <= '0;
               disp_idx <= '0;
            end
         end
      end
   end

   assign disp    = (count != '0) ? mem[disp_idx] : 8'h00;
   assign full    = (count == CW'(DEPTH));
   assign running = (state == RUN);
   assign busy    = (state == CLEAR);

endmodule

// File: tb/tb_byte_scan_ctrl.sv
// Directed testbench for byte_scan_ctrl with DEPTH=4, TICK_DIV=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_byte_scan_ctrl;

   localparam int DEPTH    = 4;
   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_p, clr_p, run_p;
   logic [7:0] sw;
   logic [7:0] disp;
   logic [1:0] disp_idx;
   logic [2:0] count;
   logic       full, running, busy;

   int n_checks = 0;
   int n_pass   = 0;

   byte_scan_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_p   (load_p),
      .clr_p    (clr_p),
      .run_p    (run_p),
      .sw       (sw),
      .disp     (disp),
      .disp_idx (disp_idx),
      .count    (count),
      .full     (full),
      .running  (running),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
         $display("check %-14s got %0h expected %0h ok", tag, obs, exp);
      end else begin
         $display("FAIL %-14s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply pulses for one cycle starting at the current falling edge; returns
   // at the next falling edge, where the result of that edge is visible.
   task automatic step(input logic l, input logic c, input logic r, input logic [7:0] s);
      load_p = l; clr_p = c; run_p = r; sw = s;
      @(negedge clk);
      load_p = 1'b0; clr_p = 1'b0; run_p = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      logic [7:0] scroll [3];
      scroll[0] = 8'h11; scroll[1] = 8'h22; scroll[2] = 8'h33;

      rst_n = 1'b0; load_p = 1'b0; clr_p = 1'b0; run_p = 1'b0; sw = 8'h00;
      idle(3);
      rst_n = 1'b1;
      check("rst_count", count, 0);
      check("rst_disp", disp, 8'h00);
      check("rst_idx", disp_idx, 0);
      check("rst_flags", {full, running, busy}, 3'b000);

      // two loads: newest entry shown
      step(1, 0, 0, 8'hA5);
      check("load1_disp", disp, 8'hA5);
      step(1, 0, 0, 8'h3C);
      check("load2_count", count, 2);
      check("load2_idx", disp_idx, 1);
      check("load2_disp", disp, 8'h3C);

      // clear from EDIT: busy for exactly DEPTH cycles
      step(0, 1, 0, 8'h00);
      check("clr_busy1", busy, 1);
      check("clr_disp", disp, 8'h00);
      for (int i = 2; i <= DEPTH; i++) begin
         idle(1);
         check("clr_busy_n", busy, 1);
      end
      idle(1);
      check("clr_done", busy, 0);
      check("clr_count", count, 0);

      // fill the bank, fifth load ignored
      for (int i = 1; i <= 5; i++) begin
         step(1, 0, 0, 8'(i));
         if (i == 4) begin
            check("fill_full", full, 1);
            check("fill_count4", count, 4);
         end
      end
      check("over_count", count, 4);
      check("over_idx", disp_idx, 3);
      check("over_mem3", disp, 8'h04);

      // empty bank, then run_p is ignored
      step(0, 1, 0, 8'h00);
      idle(DEPTH);
      check("clr2_busy", busy, 0);
      step(0, 0, 1, 8'h00);
      check("run_empty", running, 0);

      // scroll through three entries
      for (int i = 0; i < 3; i++) step(1, 0, 0, scroll[i]);
      check("ld3_disp", disp, 8'h33);
      step(0, 0, 1, 8'h00);   // cycle k=1 of RUN
      check("run_on", running, 1);
      for (int k = 1; k <= 17; k++) begin
         if (k > 1) idle(1);
         check("scroll_disp", disp, scroll[((k - 1) / TICK_DIV) % 3]);
      end
      // stop at k=17 with disp_idx=1; it must stay frozen
      step(0, 0, 1, 8'h00);
      check("stop_run", running, 0);
      check("stop_idx", disp_idx, 1);
      idle(6);
      check("frozen_idx", disp_idx, 1);
      check("frozen_disp", disp, 8'h22);

      // clr+load+run together in RUN -> CLEAR, pulses during busy ignored
      step(0, 0, 1, 8'h00);
      check("rerun", running, 1);
      step(1, 1, 1, 8'hFF);
      check("combo_busy", busy, 1);
      check("combo_count", count, 0);
      check("combo_run", running, 0);
      step(1, 0, 1, 8'h77);
      check("busy2", busy, 1);
      step(1, 1, 0, 8'h66);
      check("busy3", busy, 1);
      idle(1);
      check("busy4", busy, 1);
      idle(1);
      check("combo_done", busy, 0);
      check("combo_cnt0", count, 0);
      check("combo_disp0", disp, 8'h00);
      check("combo_edit", running, 0);

      // reset in the middle of a clear
      step(1, 0, 0, 8'hAB);
      check("pre_rst_disp", disp, 8'hAB);
      step(0, 1, 0, 8'h00);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_count", count, 0);
      check("midrst_disp", disp, 8'h00);
      check("midrst_run", running, 0);
      // bank usable after aborted clear
      step(1, 0, 0, 8'h5A);
      check("post_rst_disp", disp, 8'h5A);
      check("post_rst_idx", disp_idx, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
